// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with a prefetch queue.
//
// Issues one instruction-memory request at a time, but only while the
// prefetch FIFO has room for the returned word. Each fetched word is
// buffered with its PC and offered to the decoder through a valid/ready
// pair. A jump flushes the queue and restarts fetch at the jump target.
// A request that is still outstanding when a jump arrives cannot be
// withdrawn. The stage waits in DROP until that request is acknowledged
// and discards the returned word.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   jump         redirect request
//   jump_target  redirect byte address (bits [1:0] ignored)
//   imem_req     registered memory request
//   imem_addr    registered request address, stable while imem_req is high
//   imem_ack     memory acknowledge
//   imem_rdata   instruction word, valid with imem_ack
//   instr_valid  FIFO head valid
//   instr        FIFO head instruction (0 when empty)
//   pc_out       FIFO head PC (0 when empty)
//   instr_ready  decoder accepts head
module if_stage #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  input  logic        instr_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   mem_pc_q  [DEPTH];
  logic [31:0]   mem_ins_q [DEPTH];
  logic          push, pop;
  logic [31:0]   target_aligned;
  logic          unused_target_lsbs;

  assign target_aligned     = {jump_target[31:2], 2'b00};
  assign unused_target_lsbs = ^jump_target[1:0];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (jump) begin
      rd_d       = '0;
      wr_d       = '0;
      cnt_d      = '0;
      fetch_pc_d = target_aligned;
      // An unacknowledged request cannot be withdrawn, so its response must be drained first.
      if ((state_q == REQ || state_q == DROP) && !imem_ack) begin
        state_d = DROP;
      end else begin
        state_d = REQ;
      end
    end else begin
      pop  = instr_valid && instr_ready;
      push = (state_q == REQ) && imem_ack;
      if (push) begin
        wr_d       = wr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
      case (state_q)
        IDLE: if (cnt_q < FULL) state_d = REQ;
        REQ:  if (imem_ack) state_d = (cnt_d < FULL) ? REQ : IDLE;
        DROP: if (imem_ack) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end

    // The bus address follows fetch_pc except while the stale request is being drained.
    addr_d = (state_d == DROP) ? addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
    end
  end

  // FIFO storage needs no reset; the head is masked whenever count is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[wr_q]  <= fetch_pc_q;
      mem_ins_q[wr_q] <= imem_rdata;
    end
  end

  assign imem_req    = (state_q != IDLE);
  assign imem_addr   = addr_q;
  assign instr_valid = (cnt_q != '0);
  assign instr       = instr_valid ? mem_ins_q[rd_q] : '0;
  assign pc_out      = instr_valid ? mem_pc_q[rd_q]  : '0;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        instr_ready;

  always #5 clk = ~clk;

  if_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .jump        (jump),
    .jump_target (jump_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc_out      (pc_out),
    .instr_ready (instr_ready)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: expected queue contents plus request bookkeeping.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  logic [31:0] popped[$];
  logic [31:0] exp_pc, stale_addr, pend_addr, last_pc;
  bit          stale, pend, have_last;

  task automatic model_reset();
    q.delete();
    popped.delete();
    exp_pc    = RESET_PC;
    stale     = 0;
    pend      = 0;
    have_last = 0;
  endtask

  task automatic drive(input bit a, input bit r, input bit j, input logic [31:0] t);
    imem_ack    = a & imem_req;
    imem_rdata  = imem_addr ^ KEY;
    instr_ready = r;
    jump        = j;
    jump_target = t;
  endtask

  // Compare outputs against the model, advance the model, then step one clock.
  task automatic cycle();
    ent_t        e;
    logic [64:0] act, expv;
    act  = {instr_valid, pc_out, instr};
    expv = (q.size() > 0) ? {1'b1, q[0].pc, q[0].ins} : 65'd0;
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL head: got %h expected %h", act, expv);
    end
    if (pend) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== pend_addr) begin
        failures++;
        $display("FAIL hold: req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, pend_addr);
      end
    end
    if (imem_req === 1'b1 && !stale) begin
      checks++;
      if (imem_addr !== exp_pc) begin
        failures++;
        $display("FAIL fetch_addr: got %h expected %h", imem_addr, exp_pc);
      end
      checks++;
      if (q.size() >= DEPTH) begin
        failures++;
        $display("FAIL room: request with %0d entries queued, expected < %0d", q.size(), DEPTH);
      end
    end
    if (imem_req === 1'b1 && stale) begin
      checks++;
      if (imem_addr !== stale_addr) begin
        failures++;
        $display("FAIL stale_addr: got %h expected %h", imem_addr, stale_addr);
      end
    end

    pend      = imem_req && !imem_ack;
    pend_addr = imem_addr;
    if (jump) begin
      q.delete();
      have_last = 0;
      if (imem_req && !imem_ack) begin
        if (!stale) stale_addr = imem_addr;
        stale = 1;
      end else begin
        stale = 0;
      end
      exp_pc = {jump_target[31:2], 2'b00};
    end else begin
      if (q.size() > 0 && instr_ready) begin
        e = q.pop_front();
        popped.push_back(e.pc);
        if (have_last) begin
          checks++;
          if (e.pc !== last_pc + 32'd4) begin
            failures++;
            $display("FAIL stream: popped pc %h expected %h", e.pc, last_pc + 32'd4);
          end
        end
        last_pc   = e.pc;
        have_last = 1;
      end
      if (imem_req && imem_ack) begin
        if (stale) stale = 0;
        else begin
          q.push_back({imem_addr, imem_rdata});
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; jump = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    jump_target = '0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b0; jump = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    jump_target = '0; imem_rdata = '0;
    #1;
    checks++;
    if ({imem_req, imem_addr, instr_valid, instr, pc_out} !== {1'b0, RESET_PC, 1'b0, 64'd0}) begin
      failures++;
      $display("FAIL reset_outputs: req=%b addr=%h valid=%b instr=%h pc=%h", imem_req, imem_addr, instr_valid, instr, pc_out);
    end
    do_reset();
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_cycle0: req=%b expected 0", imem_req);
    end
    drive(0, 0, 0, 0);
    cycle();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      failures++;
      $display("FAIL reset_cycle1: req=%b addr=%h expected 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 24; i++) begin
      drive(1, 1, 0, 0);
      cycle();
    end
    checks++;
    if (popped.size() != 22) begin
      failures++;
      $display("FAIL stream_count: got %0d pops expected 22", popped.size());
    end
    for (int i = 0; i < popped.size(); i++) begin
      checks++;
      if (popped[i] !== 32'(4 * i)) begin
        failures++;
        $display("FAIL stream_pc[%0d]: got %h expected %h", i, popped[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 0, 0);
      cycle();
      if (q.size() == DEPTH && !imem_req) break;
    end
    repeat (2) begin
      drive(1, 0, 0, 0);
      cycle();
    end
    checks++;
    if (q.size() != DEPTH || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL full_idle: pushes=%0d req=%b expected %0d and 0", q.size(), imem_req, DEPTH);
    end
    popped.delete();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0);
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= popped.size() || popped[i] !== 32'(4 * i)) begin
        failures++;
        $display("FAIL drain_pc[%0d]: got %h expected %h", i, (i < popped.size()) ? popped[i] : 32'hx, 32'(4 * i));
      end
    end
    for (int i = 0; i < 6 && !imem_req; i++) begin
      drive(0, 1, 0, 0);
      cycle();
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      failures++;
      $display("FAIL resume: req=%b addr=%h expected 1 00000010", imem_req, imem_addr);
    end
  endtask

  task automatic test_jump_pending();
    do_reset();
    for (int i = 0; i < 20 && !(imem_req && imem_addr == 32'h10); i++) begin
      drive(1, 1, 0, 0);
      cycle();
    end
    checks++;
    if (!(imem_req === 1'b1 && imem_addr === 32'h10)) begin
      failures++;
      $display("FAIL reach_0x10: req=%b addr=%h expected 1 00000010", imem_req, imem_addr);
    end
    drive(0, 1, 0, 0);
    cycle();
    drive(0, 1, 1, 32'h103);
    cycle();
    checks++;
    if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h10}) begin
      failures++;
      $display("FAIL drop_hold: valid=%b req=%b addr=%h expected 0 1 00000010", instr_valid, imem_req, imem_addr);
    end
    drive(1, 1, 0, 0);
    imem_rdata = 32'h0000_DEAD;
    cycle();
    checks++;
    if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
      failures++;
      $display("FAIL redirect: valid=%b req=%b addr=%h expected 0 1 00000100", instr_valid, imem_req, imem_addr);
    end
    for (int i = 0; i < 10 && !instr_valid; i++) begin
      drive(1, 0, 0, 0);
      cycle();
    end
    checks++;
    if ({instr_valid, pc_out, instr} !== {1'b1, 32'h100, 32'h100 ^ KEY}) begin
      failures++;
      $display("FAIL first_target: valid=%b pc=%h instr=%h expected 1 00000100 %h", instr_valid, pc_out, instr, 32'h100 ^ KEY);
    end
  endtask

  task automatic test_jump_with_ack();
    do_reset();
    for (int i = 0; i < 20 && !(imem_req && imem_addr == 32'h8); i++) begin
      drive(1, 0, 0, 0);
      cycle();
    end
    drive(1, 0, 1, 32'h40);
    imem_rdata = 32'h0000_BEEF;
    cycle();
    checks++;
    if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h40}) begin
      failures++;
      $display("FAIL jump_ack: valid=%b req=%b addr=%h expected 0 1 00000040", instr_valid, imem_req, imem_addr);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 0);
      cycle();
      checks++;
      if (instr_valid === 1'b1 && instr === 32'h0000_BEEF) begin
        failures++;
        $display("FAIL beef_leak: instr=%h expected not 0000beef", instr);
      end
    end
  endtask

  task automatic test_random();
    int dly;
    bit a;
    do_reset();
    dly = -1;
    for (int i = 0; i < 800; i++) begin
      if (imem_req && dly < 0) dly = $urandom_range(0, 5);
      a = imem_req && (dly == 0);
      drive(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 3), $urandom);
      cycle();
      if (a) dly = -1;
      else if (dly > 0) dly--;
    end
    checks++;
    if (popped.size() < 50) begin
      failures++;
      $display("FAIL random_progress: got %0d pops expected >= 50", popped.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 20 && q.size() < 2; i++) begin
      drive(1, 0, 0, 0);
      cycle();
    end
    drive(0, 0, 0, 0);
    cycle();
    checks++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: valid=%b req=%b expected 1 1", instr_valid, imem_req);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({imem_req, instr_valid, instr, pc_out} !== 66'd0) begin
      failures++;
      $display("FAIL async_reset: req=%b valid=%b instr=%h pc=%h expected all 0", imem_req, instr_valid, instr, pc_out);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    drive(1, 1, 0, 0);
    cycle();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      failures++;
      $display("FAIL restart: req=%b addr=%h expected 1 %h", imem_req, imem_addr, RESET_PC);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 0, 0);
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_jump_pending();
    test_jump_with_ack();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
